// File: rtl/imem_sync.sv
// Loadable synchronous instruction memory with a registered fetch handshake.
// Optional accepted-fetch counter is built only when IMEM_FETCH_CNT_EN is defined.
module imem_sync #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] NOOP_WORD  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] PC,
    output logic                  fetch_ready,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  instr_valid,
    output logic                  out_of_range,
    input  logic                  load_start,
    input  logic                  load_we,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_done,
    output logic                  load_err,
    output logic [31:0]           fetch_count
);

    localparam int                    IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    logic [0:0]            state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      written;

    logic                  fetch_accept;
    logic                  enter_load;
    logic                  load_write;
    logic                  fetch_in_range;
    logic                  load_in_range;
    logic [IDX_W-1:0]      fetch_idx;
    logic [IDX_W-1:0]      load_idx;
    logic [DATA_WIDTH-1:0] fetch_word;

    assign fetch_ready    = (state == ST_RUN);
    assign fetch_accept   = fetch_req & fetch_ready;
    assign enter_load     = load_start & (state == ST_RUN);
    assign load_write     = load_we & (state == ST_LOAD);

    // Full-width compares: out-of-range PCs must never alias onto low words.
    assign fetch_in_range = (PC < DEPTH_LIMIT);
    assign load_in_range  = (load_addr < DEPTH_LIMIT);
    assign fetch_idx      = PC[IDX_W-1:0];
    assign load_idx       = load_addr[IDX_W-1:0];

    // NOTE: default assigned first so every path drives fetch_word and no latch is inferred.
    always_comb begin
        fetch_word = NOOP_WORD;
        if (fetch_in_range && written[fetch_idx]) begin
            fetch_word = mem[fetch_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else if (state == ST_RUN) begin
            if (load_start) begin
                state <= ST_LOAD;
            end
        end else begin
            if (load_done) begin
                state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Instruction  <= NOOP_WORD;
            instr_valid  <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            instr_valid <= fetch_accept;
            if (fetch_accept) begin
                Instruction  <= fetch_word;
                out_of_range <= ~fetch_in_range;
            end
        end
    end

    // Validity lives in the written bits, so clearing them invalidates the whole array at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written  <= '0;
            load_err <= 1'b0;
        end else if (enter_load) begin
            written  <= '0;
            load_err <= 1'b0;
        end else if (load_write) begin
            if (load_in_range) begin
                written[load_idx] <= 1'b1;
            end else begin
                load_err <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; stale contents are masked by the written bits.
    always_ff @(posedge clk) begin
        if (load_write && load_in_range) begin
            mem[load_idx] <= load_data;
        end
    end

`ifdef IMEM_FETCH_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (enter_load) begin
            fetch_count <= '0;
        end else if (fetch_accept && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_imem_sync.sv
// Randomised self-checking bench for imem_sync against a behavioural memory model,
// plus directed sequences with literal expectations.
module tb_imem_sync;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] PC = '0;
    logic        fetch_ready;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic        out_of_range;
    logic        load_start = 1'b0;
    logic        load_we = 1'b0;
    logic [15:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        load_done = 1'b0;
    logic        load_err;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    imem_sync dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req    (fetch_req),
        .PC           (PC),
        .fetch_ready  (fetch_ready),
        .Instruction  (Instruction),
        .instr_valid  (instr_valid),
        .out_of_range (out_of_range),
        .load_start   (load_start),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_done    (load_done),
        .load_err     (load_err),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word array with a valid flag per word and a mode bit.
    bit          m_loading = 1'b0;
    logic [31:0] m_mem [DEPTH];
    bit          m_wr  [DEPTH];
    logic [31:0] m_instr = '0;
    bit          m_valid = 1'b0;
    bit          m_oor   = 1'b0;
    bit          m_err   = 1'b0;
    logic [31:0] m_cnt   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loading = 1'b0;
            foreach (m_wr[i]) m_wr[i] = 1'b0;
            m_instr = '0;
            m_valid = 1'b0;
            m_oor   = 1'b0;
            m_err   = 1'b0;
            m_cnt   = '0;
        end else begin
            bit accept;
            accept = fetch_req && !m_loading;
            m_valid = accept;
            if (accept) begin
                if (int'(PC) >= DEPTH) begin
                    m_instr = '0;
                    m_oor   = 1'b1;
                end else begin
                    m_instr = m_wr[int'(PC)] ? m_mem[int'(PC)] : 32'h0;
                    m_oor   = 1'b0;
                end
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
            if (!m_loading) begin
                if (load_start) begin
                    m_loading = 1'b1;
                    foreach (m_wr[i]) m_wr[i] = 1'b0;
                    m_err = 1'b0;
                    m_cnt = '0;
                end
            end else begin
                if (load_we) begin
                    if (int'(load_addr) < DEPTH) begin
                        m_mem[int'(load_addr)] = load_data;
                        m_wr[int'(load_addr)]  = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (load_done) m_loading = 1'b0;
            end
        end
    end

    function automatic logic [31:0] exp_count();
`ifdef IMEM_FETCH_CNT_EN
        return m_cnt;
`else
        return 32'h0;
`endif
    endfunction

    // Every-cycle comparison, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        check("fetch_ready",  fetch_ready,  !m_loading);
        check("instr_valid",  instr_valid,  m_valid);
        check("Instruction",  Instruction,  m_instr);
        check("out_of_range", out_of_range, m_oor);
        check("load_err",     load_err,     m_err);
        check("fetch_count",  fetch_count,  exp_count());
    end

    task automatic idle();
        fetch_req  = 1'b0;
        load_start = 1'b0;
        load_we    = 1'b0;
        load_done  = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        step();
        step();
        #2 rst = 1'b0;
        step();
    endtask

    task automatic fetch(input logic [15:0] addr);
        idle();
        fetch_req = 1'b1;
        PC = addr;
        step();
        idle();
    endtask

    task automatic load_write(input logic [15:0] addr, input logic [31:0] data, input bit done);
        idle();
        load_we   = 1'b1;
        load_addr = addr;
        load_data = data;
        load_done = done;
        step();
        idle();
    endtask

    task automatic enter_load();
        idle();
        load_start = 1'b1;
        step();
        idle();
    endtask

    task automatic leave_load();
        idle();
        load_done = 1'b1;
        step();
        idle();
    endtask

    initial begin
        idle();
        #1 rst = 1'b1;
        step();
        step();
        #2 rst = 1'b0;
        step();

        // Reset then fetch of an unwritten word.
        check("rst_ready", fetch_ready, 1'b1);
        fetch(16'd0);
        check("t1_valid", instr_valid, 1'b1);
        check("t1_instr", Instruction, 32'h0);
        check("t1_oor", out_of_range, 1'b0);

        // Load two words, fetch them back to back.
        enter_load();
        load_write(16'd0, 32'hE421_0007, 1'b0);
        load_write(16'd1, 32'h4800_0000, 1'b0);
        leave_load();
        idle();
        fetch_req = 1'b1;
        PC = 16'd0;
        step();
        check("t2_valid0", instr_valid, 1'b1);
        check("t2_instr0", Instruction, 32'hE421_0007);
        PC = 16'd1;
        step();
        idle();
        check("t2_valid1", instr_valid, 1'b1);
        check("t2_instr1", Instruction, 32'h4800_0000);

        // Out-of-range fetch and load write.
        fetch(16'd64);
        check("t3_instr", Instruction, 32'h0);
        check("t3_oor", out_of_range, 1'b1);
        enter_load();
        load_write(16'd0, 32'hA5A5_0001, 1'b0);
        load_write(16'h0040, 32'hDEAD_BEEF, 1'b0);
        check("t3_err", load_err, 1'b1);
        leave_load();
        fetch(16'd0);
        check("t3_addr0", Instruction, 32'hA5A5_0001);
        check("t3_err_sticky", load_err, 1'b1);

        // Fetch refused while loading; write and done in one cycle.
        enter_load();
        fetch_req = 1'b1;
        PC = 16'd0;
        check("t4_ready", fetch_ready, 1'b0);
        step();
        check("t4_no_valid", instr_valid, 1'b0);
        load_write(16'd5, 32'h1234_5678, 1'b1);
        fetch(16'd5);
        check("t4_instr", Instruction, 32'h1234_5678);

        // Reset in the middle of a load.
        enter_load();
        load_write(16'd0, 32'h1111_1111, 1'b0);
        load_write(16'd1, 32'h2222_2222, 1'b0);
        load_write(16'd2, 32'h3333_3333, 1'b0);
        do_reset();
        check("t5_ready", fetch_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            fetch(16'(i));
            check("t5_instr", Instruction, 32'h0);
        end

        // Fetch counter.
        do_reset();
        for (int i = 0; i < 10; i++) fetch(16'(i));
`ifdef IMEM_FETCH_CNT_EN
        check("t6_count10", fetch_count, 32'd10);
`else
        check("t6_count10", fetch_count, 32'd0);
`endif
        enter_load();
        check("t6_count_clr", fetch_count, 32'd0);
        leave_load();

        // Randomised traffic, including inputs that must be ignored in each mode.
        for (int n = 0; n < 3000; n++) begin
            int r;
            fetch_req  = ($urandom_range(0, 3) != 0);
            load_start = ($urandom_range(0, 29) == 0);
            load_we    = ($urandom_range(0, 1) == 1);
            load_done  = ($urandom_range(0, 9) == 0);
            load_data  = $urandom;
            r = $urandom_range(0, 9);
            if (r < 7)       PC = 16'($urandom_range(0, 70));
            else if (r < 9)  PC = 16'($urandom_range(0, 65535)) | 16'h0040;
            else             PC = 16'hFFFF;
            r = $urandom_range(0, 9);
            if (r < 8)       load_addr = 16'($urandom_range(0, 63));
            else             load_addr = 16'($urandom_range(0, 65535)) | 16'h0040;
            step();
        end
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
